// File: rtl/fifo_chk_pkg.sv
// Shared types for the single-clock FIFO shadow checker: error codes,
// sticky-bit positions and the first-error priority encoder.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    OVER  = 2'd0,
    UNDER = 2'd1,
    DATA  = 2'd2,
    FLAG  = 2'd3
  } err_code_e;

  localparam int ERR_W     = 4;
  localparam int ERR_OVER  = 0;
  localparam int ERR_UNDER = 1;
  localparam int ERR_DATA  = 2;
  localparam int ERR_FLAG  = 3;

  // Highest-priority error present in one cycle's event vector.
  function automatic err_code_e first_code(input logic [ERR_W-1:0] ev);
    err_code_e code;
    if (ev[ERR_OVER]) begin
      code = OVER;
    end else if (ev[ERR_UNDER]) begin
      code = UNDER;
    end else if (ev[ERR_DATA]) begin
      code = DATA;
    end else begin
      code = FLAG;
    end
    return code;
  endfunction

endpackage

// File: rtl/fifo_chk_queue.sv
// Reference queue for the FIFO checker: shadow RAM, wrapping head/tail
// pointers and an occupancy counter, plus overflow/underflow detection.
module fifo_chk_queue
  import fifo_chk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic                         re,
  input  logic [WIDTH-1:0]             wdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head,
  output logic                         pop,
  output logic                         over,
  output logic                         under
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_s, empty_s, push_s, pop_s;

  // Push/pop legality; a read on a full queue frees the slot for a same-cycle write.
  always_comb begin
    full_s  = (level_q == LVL_FULL);
    empty_s = (level_q == {LVL_W{1'b0}});
    pop_s   = re && !empty_s;
    push_s  = we && (!full_s || re);
    over    = we && full_s && !re;
    under   = re && empty_s;
  end

  // Next pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Shadow storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];
  assign pop   = pop_s;

endmodule

// File: rtl/fifo_chk_model.sv
// Cycle-accurate shadow checker for a single-clock FIFO: compares DUT read
// data and flags against a reference queue and records error status.
module fifo_chk_model
  import fifo_chk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int RD_LAT    = 1,
  parameter int ERR_CNT_W = 8,
  parameter int TIME_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic                         re,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [WIDTH-1:0]             data_out,
  input  logic                         dut_full,
  input  logic                         dut_empty,
  input  logic                         clr,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [3:0]                   err_sticky,
  output logic [ERR_CNT_W-1:0]         err_cnt,
  output logic [1:0]                   first_err_code,
  output logic [TIME_W-1:0]            first_err_time,
  output logic                         first_err_vld
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0]     LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
  localparam logic [TIME_W-1:0]    STAMP_MAX = {TIME_W{1'b1}};

  // Four-state inequality so an unknown DUT output is a mismatch.
  function automatic logic data_mismatch(input logic [WIDTH-1:0] act,
                                         input logic [WIDTH-1:0] exp);
    return (act !== exp);
  endfunction

  logic [LVL_W-1:0]     level_s;
  logic [WIDTH-1:0]     head_s;
  logic                 pop_s, over_s, under_s;
  logic                 data_err_s, flag_err_s;
  logic [ERR_W-1:0]     err_now_s;

  logic [ERR_W-1:0]     err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  err_code_e            fcode_q, fcode_d;
  logic [TIME_W-1:0]    ftime_q, ftime_d;
  logic                 fvld_q, fvld_d;
  logic [TIME_W-1:0]    stamp_q, stamp_d;

  fifo_chk_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .wdata (data_in),
    .level (level_s),
    .head  (head_s),
    .pop   (pop_s),
    .over  (over_s),
    .under (under_s)
  );

  if (RD_LAT == 0) begin : g_lat0
    // Read data is valid alongside re; compare against the current head.
    always_comb begin
      data_err_s = pop_s && data_mismatch(data_out, head_s);
    end
  end else begin : g_lat1
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] exp_q, exp_d;

    // Capture the popped head and compare it on the following cycle.
    always_comb begin
      pend_d     = pop_s;
      exp_d      = pop_s ? head_s : exp_q;
      data_err_s = pend_q && data_mismatch(data_out, exp_q);
    end

    // Pending-compare pipeline; clr deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
        exp_q  <= {WIDTH{1'b0}};
      end else begin
        pend_q <= pend_d;
        exp_q  <= exp_d;
      end
    end
  end

  // Flags are judged against the occupancy held before this edge.
  always_comb begin
    flag_err_s = (dut_full  != (level_s == LVL_FULL)) ||
                 (dut_empty != (level_s == {LVL_W{1'b0}}));
    err_now_s            = {ERR_W{1'b0}};
    err_now_s[ERR_OVER]  = over_s;
    err_now_s[ERR_UNDER] = under_s;
    err_now_s[ERR_DATA]  = data_err_s;
    err_now_s[ERR_FLAG]  = flag_err_s;
  end

  // Status update: clr beats any error raised in the same cycle.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    fcode_d      = fcode_q;
    ftime_d      = ftime_q;
    fvld_d       = fvld_q;
    stamp_d      = (stamp_q == STAMP_MAX) ? stamp_q : (stamp_q + TIME_W'(1));
    if (clr) begin
      err_sticky_d = {ERR_W{1'b0}};
      err_cnt_d    = {ERR_CNT_W{1'b0}};
      fcode_d      = OVER;
      ftime_d      = {TIME_W{1'b0}};
      fvld_d       = 1'b0;
    end else if (|err_now_s) begin
      err_sticky_d = err_sticky_q | err_now_s;
      err_cnt_d    = (err_cnt_q == CNT_MAX) ? err_cnt_q : (err_cnt_q + ERR_CNT_W'(1));
      if (!fvld_q) begin
        fcode_d = first_code(err_now_s);
        ftime_d = stamp_q;
        fvld_d  = 1'b1;
      end else begin
        fvld_d  = fvld_q;
      end
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // Status and timestamp registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= {ERR_W{1'b0}};
      err_cnt_q    <= {ERR_CNT_W{1'b0}};
      fcode_q      <= OVER;
      ftime_q      <= {TIME_W{1'b0}};
      fvld_q       <= 1'b0;
      stamp_q      <= {TIME_W{1'b0}};
    end else begin
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      fcode_q      <= fcode_d;
      ftime_q      <= ftime_d;
      fvld_q       <= fvld_d;
      stamp_q      <= stamp_d;
    end
  end

  assign level          = level_s;
  assign err_sticky     = err_sticky_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_code = fcode_q;
  assign first_err_time = ftime_q;
  assign first_err_vld  = fvld_q;

endmodule

// File: tb/tb_fifo_chk_model.sv
// Bench for fifo_chk_model: RD_LAT=0 and RD_LAT=1 instances against a queue-based reference.
module tb_fifo_chk_model;

  logic       clk, rst, we, re, clr, dut_full, dut_empty;
  logic [7:0] data_in, d0, d1;
  logic [2:0] lvl [2];
  logic [3:0] st [2];
  logic [7:0] cnt [2];
  logic [1:0] fc [2];
  logic [15:0] ft [2];
  logic       fv [2];

  int n_err = 0;
  int n_checks = 0;

  // Reference state
  logic [7:0] q[$];
  logic       m_pend;
  logic [7:0] m_exp;
  int         m_cyc;
  logic [3:0] m_st [2];
  int         m_cnt [2];
  int         m_fc [2];
  int         m_ft [2];
  logic       m_fv [2];

  fifo_chk_model #(.WIDTH(8), .DEPTH(4), .RD_LAT(0), .ERR_CNT_W(8), .TIME_W(16)) u0 (
    .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in), .data_out(d0),
    .dut_full(dut_full), .dut_empty(dut_empty), .clr(clr),
    .level(lvl[0]), .err_sticky(st[0]), .err_cnt(cnt[0]), .first_err_code(fc[0]),
    .first_err_time(ft[0]), .first_err_vld(fv[0]));

  fifo_chk_model #(.WIDTH(8), .DEPTH(4), .RD_LAT(1), .ERR_CNT_W(8), .TIME_W(16)) u1 (
    .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in), .data_out(d1),
    .dut_full(dut_full), .dut_empty(dut_empty), .clr(clr),
    .level(lvl[1]), .err_sticky(st[1]), .err_cnt(cnt[1]), .first_err_code(fc[1]),
    .first_err_time(ft[1]), .first_err_vld(fv[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d level", tag, i), lvl[i], q.size());
      chk($sformatf("%s u%0d sticky", tag, i), st[i], m_st[i]);
      chk($sformatf("%s u%0d cnt", tag, i), cnt[i], m_cnt[i]);
      chk($sformatf("%s u%0d fvld", tag, i), fv[i], m_fv[i]);
      chk($sformatf("%s u%0d fcode", tag, i), fc[i], m_fc[i]);
      chk($sformatf("%s u%0d ftime", tag, i), ft[i], m_ft[i]);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pend = 1'b0;
    m_exp  = 8'h00;
    m_cyc  = 0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 4'h0; m_cnt[i] = 0; m_fc[i] = 0; m_ft[i] = 0; m_fv[i] = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    we = 1'b0; re = 1'b0; clr = 1'b0; data_in = 8'h00; d0 = 8'h00; d1 = 8'h00;
    dut_full = 1'b0; dut_empty = 1'b1;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all(tag);
  endtask

  // One clock: drive inputs, advance the reference by the rules, compare after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] din,
                      input logic [7:0] dout1, input logic c,
                      input logic flip_f, input logic flip_e, input logic [7:0] x0);
    int         n;
    logic       ov, un, fl, pop;
    logic [3:0] ev [2];
    logic [7:0] dd0;
    n   = q.size();
    pop = r && (n > 0);
    dd0 = 8'($urandom);
    if (pop) dd0 = q[0] ^ x0;
    we = w; re = r; data_in = din; d0 = dd0; d1 = dout1; clr = c;
    dut_full  = (n == 4) ^ flip_f;
    dut_empty = (n == 0) ^ flip_e;
    ov = w && (n == 4) && !r;
    un = r && (n == 0);
    fl = flip_f || flip_e;
    ev[0] = {fl, pop && (dd0 !== q[0]), un, ov};
    ev[1] = {fl, m_pend && (dout1 !== m_exp), un, ov};
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_st[i] = 4'h0; m_cnt[i] = 0; m_fc[i] = 0; m_ft[i] = 0; m_fv[i] = 1'b0;
      end else if (ev[i] != 4'h0) begin
        m_st[i] |= ev[i];
        if (m_cnt[i] < 255) m_cnt[i]++;
        if (!m_fv[i]) begin
          m_fv[i] = 1'b1;
          m_ft[i] = m_cyc;
          m_fc[i] = ev[i][0] ? 0 : ev[i][1] ? 1 : ev[i][2] ? 2 : 3;
        end
      end
    end
    m_pend = pop;
    if (pop) begin
      m_exp = q[0];
      void'(q.pop_front());
    end
    if (w && !ov) q.push_back(din);
    if (m_cyc < 65535) m_cyc++;
    #1;
    check_all("step");
  endtask

  typedef struct {
    logic       w, r;
    logic [7:0] din, dout;
    logic       c;
    int         e_lvl;
    logic [3:0] e_st;
    int         e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic w, input logic r, input logic [7:0] din, input logic [7:0] dout,
                     input logic c, input int e_lvl, input logic [3:0] e_st, input int e_cnt);
    vec_t v;
    v.w = w; v.r = r; v.din = din; v.dout = dout; v.c = c;
    v.e_lvl = e_lvl; v.e_st = e_st; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    // Directed table for the RD_LAT=1 instance: dout is what the DUT returns this cycle.
    add(1,0,8'h11,8'h00,0, 1,4'h0,0); add(1,0,8'h22,8'h00,0, 2,4'h0,0);
    add(1,0,8'h33,8'h00,0, 3,4'h0,0); add(1,0,8'h44,8'h00,0, 4,4'h0,0);
    add(0,1,8'h00,8'h00,0, 3,4'h0,0); add(0,1,8'h00,8'h11,0, 2,4'h0,0);
    add(0,1,8'h00,8'h22,0, 1,4'h0,0); add(0,1,8'h00,8'h33,0, 0,4'h0,0);
    add(0,0,8'h00,8'h44,0, 0,4'h0,0);
    add(1,0,8'h01,8'h00,0, 1,4'h0,0); add(1,0,8'h02,8'h00,0, 2,4'h0,0);
    add(1,0,8'h03,8'h00,0, 3,4'h0,0); add(1,0,8'h04,8'h00,0, 4,4'h0,0);
    add(1,0,8'h05,8'h00,0, 4,4'h1,1); add(0,0,8'h00,8'h00,1, 4,4'h0,0);
    add(0,1,8'h00,8'h00,0, 3,4'h0,0); add(0,1,8'h00,8'h01,0, 2,4'h0,0);
    add(0,1,8'h00,8'h02,0, 1,4'h0,0); add(0,1,8'h00,8'h03,0, 0,4'h0,0);
    add(0,0,8'h00,8'h04,0, 0,4'h0,0);
    add(0,1,8'h00,8'h00,0, 0,4'h2,1); add(0,0,8'h00,8'h00,1, 0,4'h0,0);
    add(1,0,8'hA5,8'h00,0, 1,4'h0,0); add(0,1,8'h00,8'h00,0, 0,4'h0,0);
    add(0,0,8'h00,8'h5A,0, 0,4'h4,1); add(0,0,8'h00,8'h00,1, 0,4'h0,0);
    add(1,0,8'h01,8'h00,0, 1,4'h0,0); add(1,0,8'h02,8'h00,0, 2,4'h0,0);
    add(1,0,8'h03,8'h00,0, 3,4'h0,0); add(1,0,8'h04,8'h00,0, 4,4'h0,0);
    add(1,1,8'h77,8'h00,0, 4,4'h0,0); add(0,1,8'h00,8'h01,0, 3,4'h0,0);
    add(0,1,8'h00,8'h02,0, 2,4'h0,0); add(0,1,8'h00,8'h03,0, 1,4'h0,0);
    add(0,1,8'h00,8'h04,0, 0,4'h0,0); add(0,0,8'h00,8'h77,0, 0,4'h0,0);

    do_reset("reset");
    foreach (tbl[k]) begin
      step(tbl[k].w, tbl[k].r, tbl[k].din, tbl[k].dout, tbl[k].c, 1'b0, 1'b0, 8'h00);
      chk($sformatf("tbl%0d level", k), lvl[1], tbl[k].e_lvl);
      chk($sformatf("tbl%0d sticky", k), st[1], tbl[k].e_st);
      chk($sformatf("tbl%0d cnt", k), cnt[1], tbl[k].e_cnt);
      if (k == 13) chk("over first code", fc[1], 0);
      if (k == 24) chk("data first code", fc[1], 2);
    end

    // dut_empty stuck low: FLAG every cycle, counter saturates, then clr wipes status.
    do_reset("reset2");
    repeat (260) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("flag sat cnt", cnt[1], 255);
    chk("flag sticky", st[1], 4'h8);
    chk("flag code", fc[1], 3);
    chk("flag time", ft[1], 0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("clr sticky", st[1], 0);
    chk("clr cnt", cnt[1], 0);
    chk("clr vld", fv[1], 0);

    // Asynchronous reset with three entries queued.
    do_reset("reset3");
    repeat (3) step(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("pre-rst level", lvl[0], 3);
    #2 rst = 1'b1;
    #1;
    chk("async rst u0 level", lvl[0], 0);
    chk("async rst u1 level", lvl[1], 0);
    do_reset("reset4");
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post-rst under", st[0], 4'h2);
    chk("post-rst under u1", st[1], 4'h2);

    // Random traffic with occasional data corruption, flag glitches and clears.
    for (int n = 0; n < 3000; n++) begin
      logic       w, r, c, ff, fe;
      logic [7:0] x0, dd1;
      w  = ($urandom_range(99) < 55);
      r  = ($urandom_range(99) < 50);
      c  = ($urandom_range(99) < 2);
      ff = ($urandom_range(99) < 3);
      fe = ($urandom_range(99) < 3);
      x0 = ($urandom_range(99) < 5) ? 8'($urandom_range(255, 1)) : 8'h00;
      dd1 = 8'($urandom);
      if (m_pend) dd1 = m_exp ^ (($urandom_range(99) < 5) ? 8'($urandom_range(255, 1)) : 8'h00);
      step(w, r, 8'($urandom), dd1, c, ff, fe, x0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
